// File: rtl/fetch_instr_queue_pkg.sv
// Shared types and constants for the fetch instruction queue: datapath width,
// default depth and the {instr, pc} entry stored per slot.
package fetch_instr_queue_pkg;

   localparam int XLEN              = 32;
   localparam int FETCH_QUEUE_DEPTH = 8;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/fetch_instr_queue.sv
// Dual-wide circular instruction queue between fetch and the two-line decoder.
// Optional saturating occupancy statistics are enabled with FETCH_QUEUE_STATS_EN.
module fetch_instr_queue
   import fetch_instr_queue_pkg::*;
#(
   parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush_i,
   input  logic            fetch_line0_valid_i,
   input  logic [XLEN-1:0] fetch_line0_instr_i,
   input  logic [XLEN-1:0] fetch_line0_pc_i,
   input  logic            fetch_line1_valid_i,
   input  logic [XLEN-1:0] fetch_line1_instr_i,
   input  logic [XLEN-1:0] fetch_line1_pc_i,
   output logic            fetch_ready_o,
   output logic            line0_valid_o,
   output logic [XLEN-1:0] line0_instr_o,
   output logic [XLEN-1:0] line0_pc_o,
   output logic            line1_valid_o,
   output logic [XLEN-1:0] line1_instr_o,
   output logic [XLEN-1:0] line1_pc_o,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [31:0]     stat_full_cycles_o,
   output logic [31:0]     stat_empty_cycles_o,
`endif
   input  logic            dec_ready_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   fq_entry_t        r_mem [DEPTH];

   logic             w_ready;
   logic             w_enq0;
   logic             w_enq1;
   logic             w_has1;
   logic             w_has2;
   logic             w_deq0;
   logic             w_deq1;
   logic [1:0]       w_enq_n;
   logic [1:0]       w_deq_n;
   logic [PTR_W-1:0] w_wr_p1;
   logic [PTR_W-1:0] w_rd_p1;

   // Ready only looks at the registered count: a dequeue this cycle gives no credit.
   assign w_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(2);

   // Slot 1 is only taken together with slot 0, so fetch order is never broken.
   assign w_enq0  = w_ready & ~flush_i & fetch_line0_valid_i;
   assign w_enq1  = w_enq0 & fetch_line1_valid_i;
   assign w_enq_n = {w_enq1, w_enq0 & ~w_enq1};

   assign w_has1  = (r_count != '0);
   assign w_has2  = (r_count >= CNT_W'(2));
   assign w_deq0  = dec_ready_i & ~flush_i & w_has1;
   assign w_deq1  = w_deq0 & w_has2;
   assign w_deq_n = {w_deq1, w_deq0 & ~w_deq1};

   assign w_wr_p1 = r_wr_ptr + PTR_W'(1);
   assign w_rd_p1 = r_rd_ptr + PTR_W'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq_n);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_enq_n);
         r_count  <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq_n);
      end
   end

   // Data storage is not reset; the line outputs are masked by count instead.
   always_ff @(posedge clk) begin
      if (w_enq0) r_mem[r_wr_ptr] <= '{instr: fetch_line0_instr_i, pc: fetch_line0_pc_i};
      if (w_enq1) r_mem[w_wr_p1]  <= '{instr: fetch_line1_instr_i, pc: fetch_line1_pc_i};
   end

   assign fetch_ready_o = w_ready;
   assign line0_valid_o = w_has1;
   assign line0_instr_o = w_has1 ? r_mem[r_rd_ptr].instr : '0;
   assign line0_pc_o    = w_has1 ? r_mem[r_rd_ptr].pc    : '0;
   assign line1_valid_o = w_has2;
   assign line1_instr_o = w_has2 ? r_mem[w_rd_p1].instr  : '0;
   assign line1_pc_o    = w_has2 ? r_mem[w_rd_p1].pc     : '0;

`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] r_stat_full;
   logic [31:0] r_stat_empty;
   logic        w_fetch_any;

   assign w_fetch_any = fetch_line0_valid_i | fetch_line1_valid_i;

   // Counters survive flush so they describe the whole run, not one redirect window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stat_full  <= '0;
         r_stat_empty <= '0;
      end else begin
         if (w_fetch_any && !w_ready && (r_stat_full != '1))
            r_stat_full <= r_stat_full + 32'd1;
         if (!w_has1 && !flush_i && (r_stat_empty != '1))
            r_stat_empty <= r_stat_empty + 32'd1;
      end
   end

   assign stat_full_cycles_o  = r_stat_full;
   assign stat_empty_cycles_o = r_stat_empty;
`endif

   a_slot1_needs_slot0: assert property (@(posedge clk) disable iff (!resetn)
      fetch_line1_valid_i |-> fetch_line0_valid_i);

endmodule
